// File: rtl/ps2_paddle_keys.sv
// PS/2 keyboard receiver plus key-state decoder for the two-player paddle game.
// Player 1 uses W/S/A/D and player 2 uses the arrow keys. Every output is registered.
module ps2_paddle_keys #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p1_left,
  output logic       p1_right,
  output logic       p2_up,
  output logic       p2_down,
  output logic       p2_left,
  output logic       p2_right,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e        r_state, w_state_next;
  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic [TW-1:0] r_idle_cnt;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_parity;
  logic          r_ext, r_brk;
  logic [7:0]    r_keys;
  logic          r_scan_valid, r_frame_err;
  logic [7:0]    r_scan_code;

  logic          w_filt_flip, w_strobe, w_timeout;
  logic          w_frame_done, w_frame_ok, w_frame_bad;
  logic          w_key_hit;
  logic [2:0]    w_key_idx;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Filtered clock flips on the FILTER_LEN-th consecutive sample that disagrees with it.
  assign w_filt_flip = (r_clk_s2 != r_clk_filt) && (r_filt_cnt == FW'(FILTER_LEN - 1));
  assign w_strobe    = w_filt_flip && !r_clk_s2;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (w_filt_flip) begin
      r_clk_filt <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state != StIdle) && !w_strobe &&
                     (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = StIdle;
    end else if (w_strobe) begin
      unique case (r_state)
        StIdle:   if (!r_dat_s2) w_state_next = StData;
        StData:   if (r_bit_cnt == 3'd7) w_state_next = StParity;
        StParity: w_state_next = StStop;
        StStop:   w_state_next = StIdle;
        default:  w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    w_frame_done = w_strobe && (r_state == StStop);
    w_frame_ok   = w_frame_done && r_dat_s2 && (^{r_shift, r_parity});
    w_frame_bad  = w_frame_done && !w_frame_ok;
  end

  always_comb begin
    w_key_hit = 1'b1;
    w_key_idx = 3'd0;
    case ({r_ext, r_shift})
      9'h01D:  w_key_idx = 3'd0;
      9'h01B:  w_key_idx = 3'd1;
      9'h01C:  w_key_idx = 3'd2;
      9'h023:  w_key_idx = 3'd3;
      9'h175:  w_key_idx = 3'd4;
      9'h172:  w_key_idx = 3'd5;
      9'h16B:  w_key_idx = 3'd6;
      9'h174:  w_key_idx = 3'd7;
      default: w_key_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_parity   <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      if (r_state == StIdle || w_strobe) r_idle_cnt <= '0;
      else                               r_idle_cnt <= r_idle_cnt + 1'b1;
      if (w_strobe) begin
        case (r_state)
          StIdle:   r_bit_cnt <= '0;
          StData: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          StParity: r_parity <= r_dat_s2;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_scan_code  <= '0;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_keys       <= '0;
    end else begin
      r_scan_valid <= w_frame_ok;
      r_frame_err  <= w_frame_bad;
      if (w_frame_ok) begin
        r_scan_code <= r_shift;
        if (r_shift == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          if (w_key_hit) r_keys[w_key_idx] <= ~r_brk;
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

  assign p1_up      = r_keys[0];
  assign p1_down    = r_keys[1];
  assign p1_left    = r_keys[2];
  assign p1_right   = r_keys[3];
  assign p2_up      = r_keys[4];
  assign p2_down    = r_keys[5];
  assign p2_left    = r_keys[6];
  assign p2_right   = r_keys[7];
  assign scan_valid = r_scan_valid;
  assign scan_code  = r_scan_code;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_paddle_keys.sv
// Scoreboard bench for ps2_paddle_keys: directed scenarios plus random byte streams,
// checked against a keyboard-level model of make/break/extended handling.
module tb_ps2_paddle_keys;

  localparam int unsigned FILT = 4;
  localparam int unsigned TMO  = 200;
  localparam int unsigned H    = 20;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       p1_up, p1_down, p1_left, p1_right;
  logic       p2_up, p2_down, p2_left, p2_right;
  logic       scan_valid, frame_err;
  logic [7:0] scan_code;

  ps2_paddle_keys #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right),
    .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right),
    .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         err;
    logic [7:0] code;
    logic [7:0] keys;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference keyboard state
  logic [7:0] m_keys = '0;
  logic [7:0] m_code = '0;
  bit         m_ext = 0, m_brk = 0;

  wire [7:0] dut_keys = {p2_right, p2_left, p2_down, p2_up, p1_right, p1_left, p1_down, p1_up};

  function automatic int key_index(input bit ext, input logic [7:0] b);
    logic [7:0] plain[4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    logic [7:0] arrow[4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    for (int i = 0; i < 4; i++) begin
      if (!ext && b == plain[i]) return i;
      if (ext && b == arrow[i]) return i + 4;
    end
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit bad);
    exp_t e;
    int   k;
    if (!bad) begin
      m_code = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        k = key_index(m_ext, b);
        if (k >= 0) m_keys[k] = !m_brk;
        m_ext = 0;
        m_brk = 0;
      end
    end
    e.err  = bad;
    e.code = m_code;
    e.keys = m_keys;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      wait_cyc(H);
      ps2_clk = 1'b0;
      wait_cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    logic par;
    par = bad ? ^b : ~^b;
    model_byte(b, bad);
    send_bits({1'b1, par, b, 1'b0}, 11);
    wait_cyc(30);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wait_cyc(1);
    reset_n = 1'b1;
    m_keys = '0;
    m_code = '0;
    m_ext  = 0;
    m_brk  = 0;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_keys"}, {24'h0, dut_keys}, 32'h0);
    check({name, "_code"}, {24'h0, scan_code}, 32'h0);
    check({name, "_pulses"}, {30'h0, scan_valid, frame_err}, 32'h0);
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && (scan_valid || frame_err)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b code=%0h with nothing expected",
                 scan_valid, frame_err, scan_code);
      end else begin
        e = q.pop_front();
        check("pulse_kind", {30'h0, frame_err, scan_valid}, e.err ? 32'h2 : 32'h1);
        check("scan_code", {24'h0, scan_code}, {24'h0, e.code});
        check("keys", {24'h0, dut_keys}, {24'h0, e.keys});
      end
    end
  end

  logic [7:0] pool[12] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23,
                           8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0};

  initial begin
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(2);
    check_idle_outputs("reset");

    // Make/break of W
    send_frame(8'h1D, 0);
    check("w_make", {31'h0, p1_up}, 32'h1);
    send_frame(8'hF0, 0);
    send_frame(8'h1D, 0);
    check("w_break", {31'h0, p1_up}, 32'h0);

    // Extended arrow make and break
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    check("p2_up_make", {30'h0, p2_up, p1_up}, 32'h2);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    check("p2_up_break", {31'h0, p2_up}, 32'h0);

    // Unmapped extended byte clears ext
    send_frame(8'hE0, 0);
    send_frame(8'h1D, 0);
    check("e0_1d_nochange", {24'h0, dut_keys}, 32'h0);
    send_frame(8'h1D, 0);
    check("plain_1d_after", {31'h0, p1_up}, 32'h1);

    // Bad parity then good frame
    send_frame(8'h1B, 1);
    check("bad_par_keep", {23'h0, p1_down, scan_code}, {23'h0, 1'b0, 8'h1D});
    send_frame(8'h1B, 0);
    check("good_after_bad", {31'h0, p1_down}, 32'h1);

    // Abandoned frame: start plus 4 data bits, then silence past the timeout
    send_bits({7'h0, 4'b0110}, 5);
    wait_cyc(TMO + 100);
    send_frame(8'h23, 0);
    check("timeout_recover", {31'h0, p1_right}, 32'h1);

    // Short low glitch with data low must not start a frame
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(FILT - 1);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(20);
    send_frame(8'hF0, 0);
    send_frame(8'h23, 0);
    check("glitch_ignored", {31'h0, p1_right}, 32'h0);

    // Reset between F0 and its code byte
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    wait_cyc(5);
    do_reset();
    wait_cyc(2);
    check_idle_outputs("mid_reset");
    send_frame(8'h1C, 0);
    check("brk_cleared", {31'h0, p1_left}, 32'h1);

    // Random byte stream, occasional parity errors
    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      if ($urandom_range(0, 3) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 11)];
      send_frame(b, $urandom_range(0, 9) == 0);
    end

    wait_cyc(100);
    check("queue_drained", q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
